// File: rtl/arch_defs_pkg.sv
// Shared flag and branch-condition definitions for the status unit.
// Latency: n/a (types and constants only); no backpressure.
package arch_defs_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    localparam int DEFAULT_STACK_DEPTH = 4;

    typedef logic [2:0] flags_t;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_Z      = 3'b001,
        COND_NZ     = 3'b010,
        COND_C      = 3'b011,
        COND_NC     = 3'b100,
        COND_N      = 3'b101,
        COND_NN     = 3'b110,
        COND_NEVER  = 3'b111
    } cond_sel_e;

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved flag words with occupancy flags and a sticky misuse error.
// Latency: write/pointer move at the request edge, read data is combinational; no backpressure (bad requests are dropped).
module flag_stack
    import arch_defs_pkg::*;
#(
    parameter int DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  logic   i_pop,
    input  flags_t i_wr_dat,
    output flags_t o_rd_dat,
    output logic   o_pop_ok,
    output logic   o_full,
    output logic   o_empty,
    output logic   o_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_ptr;
    logic          r_err;
    flags_t        r_mem [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_fault;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    // Pointer counts 0..DEPTH so full and empty are distinguishable without wrap.
    assign w_full    = (r_ptr == PW'(DEPTH));
    assign w_empty   = (r_ptr == '0);
    assign w_push_ok = i_push & ~i_pop & ~w_full;
    assign w_pop_ok  = i_pop & ~i_push & ~w_empty;
    assign w_fault   = (i_push & i_pop) | (i_push & w_full) | (i_pop & w_empty);
    assign w_wr_idx  = r_ptr[AW-1:0];
    assign w_rd_idx  = AW'(r_ptr - PW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_push_ok)
                r_ptr <= r_ptr + PW'(1);
            else if (w_pop_ok)
                r_ptr <= r_ptr - PW'(1);
            if (w_fault)
                r_err <= 1'b1;
        end
    end

    // Entries need no reset: the pointer guarantees a read only follows a write.
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok)
            r_mem[w_wr_idx] <= i_wr_dat;
    end

    assign o_rd_dat = r_mem[w_rd_idx];
    assign o_pop_ok = w_pop_ok;
    assign o_full   = w_full;
    assign o_empty  = w_empty;
    assign o_err    = r_err;

endmodule

// File: rtl/status_unit.sv
// CPU status flags {N,C,Z}: ALU capture, carry force, save/restore stack, branch condition decode.
// Latency: flag updates visible one cycle after the request; cond_true is combinational; no backpressure.
module status_unit
    import arch_defs_pkg::*;
#(
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_negative,
    input  logic       load_nzc,
    input  logic       load_nz,
    input  logic       set_carry,
    input  logic       clr_carry,
    input  logic       push,
    input  logic       pop,
    input  logic [2:0] cond_sel,
    output logic [2:0] flags,
    output logic       carry_to_alu,
    output logic       cond_true,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    flags_t r_flags;
    flags_t w_nxt_flags;
    flags_t w_pop_dat;
    logic   w_pop_ok;

    flag_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_flag_stack (
        .clk      (clk),
        .reset    (reset),
        .i_push   (push),
        .i_pop    (pop),
        .i_wr_dat (r_flags),
        .o_rd_dat (w_pop_dat),
        .o_pop_ok (w_pop_ok),
        .o_full   (stack_full),
        .o_empty  (stack_empty),
        .o_err    (stack_err)
    );

    // A rejected pop falls through so ALU/carry requests in the same cycle still land.
    always_comb begin
        w_nxt_flags = r_flags;
        if (w_pop_ok)
            w_nxt_flags = w_pop_dat;
        else if (load_nzc)
            w_nxt_flags = {alu_negative, alu_carry, alu_zero};
        else if (load_nz) begin
            w_nxt_flags[FLAG_Z] = alu_zero;
            w_nxt_flags[FLAG_N] = alu_negative;
        end else if (set_carry)
            w_nxt_flags[FLAG_C] = 1'b1;
        else if (clr_carry)
            w_nxt_flags[FLAG_C] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_flags <= '0;
        else
            r_flags <= w_nxt_flags;
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel_e'(cond_sel))
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = r_flags[FLAG_Z];
            COND_NZ:     cond_true = ~r_flags[FLAG_Z];
            COND_C:      cond_true = r_flags[FLAG_C];
            COND_NC:     cond_true = ~r_flags[FLAG_C];
            COND_N:      cond_true = r_flags[FLAG_N];
            COND_NN:     cond_true = ~r_flags[FLAG_N];
            COND_NEVER:  cond_true = 1'b0;
            default:     cond_true = 1'b0;
        endcase
    end

    assign flags        = r_flags;
    assign carry_to_alu = r_flags[FLAG_C];

endmodule

// File: tb/tb_status_unit.sv
// Directed bench for status_unit with hand-computed expected flags and stack status.
module tb_status_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_zero, alu_carry, alu_negative;
    logic       load_nzc, load_nz, set_carry, clr_carry;
    logic       push, pop;
    logic [2:0] cond_sel;
    logic [2:0] flags;
    logic       carry_to_alu, cond_true;
    logic       stack_full, stack_empty, stack_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    status_unit #(.STACK_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .load_nzc     (load_nzc),
        .load_nz      (load_nz),
        .set_carry    (set_carry),
        .clr_carry    (clr_carry),
        .push         (push),
        .pop          (pop),
        .cond_sel     (cond_sel),
        .flags        (flags),
        .carry_to_alu (carry_to_alu),
        .cond_true    (cond_true),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; load_nzc = 1'b0; load_nz = 1'b0; set_carry = 1'b0; clr_carry = 1'b0;
        push = 1'b0; pop = 1'b0;
        alu_zero = 1'b0; alu_carry = 1'b0; alu_negative = 1'b0;
    endtask

    // Advance one rising edge, then drop all request strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_alu(input logic [2:0] nzc);
        alu_negative = nzc[2];
        alu_carry    = nzc[1];
        alu_zero     = nzc[0];
    endtask

    task automatic cond_chk(input string tag, input logic [2:0] sel, input logic exp);
        cond_sel = sel;
        #1;
        check(tag, cond_true, exp);
    endtask

    task automatic stat_chk(input string tag, input logic [2:0] f, input logic full, input logic empty, input logic err);
        check({tag, ".flags"}, flags, f);
        check({tag, ".full"},  stack_full, full);
        check({tag, ".empty"}, stack_empty, empty);
        check({tag, ".err"},   stack_err, err);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
    endtask

    logic [2:0] pop_exp [4];

    initial begin
        idle();
        cond_sel = 3'b000;
        reset = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        stat_chk("reset", 3'b000, 1'b0, 1'b1, 1'b0);
        check("reset.carry_to_alu", carry_to_alu, 1'b0);
        cond_chk("reset.always", 3'b000, 1'b1);
        cond_chk("reset.never", 3'b111, 1'b0);
        cond_chk("reset.notz", 3'b010, 1'b1);

        // Arithmetic capture Z=1 C=1 N=0
        load_nzc = 1'b1; set_alu(3'b011);
        cyc();
        check("nzc.flags", flags, 3'b011);
        cond_chk("nzc.z", 3'b001, 1'b1);
        cond_chk("nzc.c", 3'b011, 1'b1);
        cond_chk("nzc.never", 3'b111, 1'b0);
        cond_chk("nzc.notc", 3'b100, 1'b0);
        cond_chk("nzc.n", 3'b101, 1'b0);
        cond_chk("nzc.notn", 3'b110, 1'b1);

        // Logic capture holds C even when ALU carry is 0
        load_nz = 1'b1; set_alu(3'b100);
        cyc();
        check("nz.flags", flags, 3'b110);
        check("nz.carry_to_alu", carry_to_alu, 1'b1);
        cond_chk("nz.n", 3'b101, 1'b1);
        clr_carry = 1'b1;
        cyc();
        check("clrc.flags", flags, 3'b100);
        set_carry = 1'b1; clr_carry = 1'b1;
        cyc();
        check("setclr.flags", flags, 3'b110);
        load_nzc = 1'b1; set_carry = 1'b1; set_alu(3'b000);
        cyc();
        check("nzc_over_set.flags", flags, 3'b000);
        load_nz = 1'b1; set_carry = 1'b1; set_alu(3'b001);
        cyc();
        check("nz_over_set.flags", flags, 3'b001);
        cyc();
        check("hold.flags", flags, 3'b001);

        // Fill the stack: each push saves the pre-update flags
        load_nzc = 1'b1; set_alu(3'b101);
        cyc();
        pop_exp[3] = 3'b101; pop_exp[2] = 3'b010; pop_exp[1] = 3'b011; pop_exp[0] = 3'b100;
        push = 1'b1; load_nzc = 1'b1; set_alu(3'b010); cyc();
        push = 1'b1; load_nzc = 1'b1; set_alu(3'b011); cyc();
        push = 1'b1; load_nzc = 1'b1; set_alu(3'b100); cyc();
        check("push3.full", stack_full, 1'b0);
        push = 1'b1; load_nzc = 1'b1; set_alu(3'b111); cyc();
        stat_chk("push4", 3'b111, 1'b1, 1'b0, 1'b0);
        push = 1'b1;
        cyc();
        stat_chk("push5", 3'b111, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            cyc();
            check($sformatf("pop%0d.flags", i), flags, pop_exp[i]);
            check($sformatf("pop%0d.full", i), stack_full, 1'b0);
            check($sformatf("pop%0d.empty", i), stack_empty, (i == 3) ? 1'b1 : 1'b0);
        end

        // Underflow: ALU load still applies
        do_reset();
        pop = 1'b1; load_nzc = 1'b1; set_alu(3'b001);
        cyc();
        stat_chk("underflow", 3'b001, 1'b0, 1'b1, 1'b1);

        // Push+pop together: pointer unchanged, carry clear still applies
        do_reset();
        check("reset2.err", stack_err, 1'b0);
        load_nzc = 1'b1; set_alu(3'b110); cyc();
        push = 1'b1; cyc();
        stat_chk("push1", 3'b110, 1'b0, 1'b0, 1'b0);
        push = 1'b1; pop = 1'b1; clr_carry = 1'b1;
        cyc();
        stat_chk("pushpop", 3'b100, 1'b0, 1'b0, 1'b1);
        pop = 1'b1;
        cyc();
        stat_chk("pushpop.after", 3'b110, 1'b0, 1'b1, 1'b1);

        // Pop beats a concurrent arithmetic load
        do_reset();
        load_nzc = 1'b1; set_alu(3'b101); cyc();
        push = 1'b1; cyc();
        load_nzc = 1'b1; set_alu(3'b010); cyc();
        pop = 1'b1; load_nzc = 1'b1; set_alu(3'b111);
        cyc();
        stat_chk("popwins", 3'b101, 1'b0, 1'b1, 1'b0);

        // Reset mid-sequence discards entries and overrides a same-cycle load
        push = 1'b1; cyc();
        push = 1'b1; cyc();
        push = 1'b1; pop = 1'b1; cyc();
        check("pre_reset.err", stack_err, 1'b1);
        reset = 1'b1; load_nzc = 1'b1; set_alu(3'b111);
        cyc();
        stat_chk("midreset", 3'b000, 1'b0, 1'b1, 1'b0);
        pop = 1'b1;
        cyc();
        stat_chk("post_reset_pop", 3'b000, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/status_unit.md
STATUS_UNIT -- requirements
Module: status_unit

Interface
REQ-001 Parameter STACK_DEPTH, default 4, SHALL set the number of flag-save entries (power of two, 2..16).
REQ-002 clk  in  1  SHALL be the clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 alu_zero  in  1  SHALL carry the ALU zero result for the current cycle.
REQ-005 alu_carry  in  1  SHALL carry the ALU carry/no-borrow result.
REQ-006 alu_negative  in  1  SHALL carry the ALU sign result.
REQ-007 load_nzc  in  1  SHALL request capture of all three ALU flags (arithmetic ops).
REQ-008 load_nz  in  1  SHALL request capture of Z and N only, with C held (logic ops).
REQ-009 set_carry, clr_carry  in  1 each  SHALL force C to 1 or 0.
REQ-010 push, pop  in  1 each  SHALL save flags to, or restore flags from, the internal flag stack.
REQ-011 cond_sel  in  3  SHALL select the branch condition (encoding per REQ-020).
REQ-012 flags  out  3  SHALL be the registered flags {N,C,Z}.
REQ-013 carry_to_alu  out  1  SHALL equal flags C, driving the ALU carry input.
REQ-014 cond_true  out  1  SHALL be the combinational result of cond_sel against the registered flags.
REQ-015 stack_full, stack_empty  out  1 each  SHALL reflect stack occupancy.
REQ-016 stack_err  out  1  SHALL be a sticky error flag.

Function
REQ-017 Flag-update priority per cycle SHALL be: pop > load_nzc > load_nz > set_carry > clr_carry; lower-priority requests are ignored in that cycle.
REQ-018 Updates SHALL take effect at the rising edge of the request cycle; flags and cond_true reflect the new value in the following cycle (one-cycle latency).
REQ-019 With no request asserted, flags SHALL hold.
REQ-020 cond_sel: 000 always, 001 Z, 010 not Z, 011 C, 100 not C, 101 N, 110 not N, 111 never.
REQ-021 push with the stack not full SHALL write the current registered flags (pre-update value of that cycle) at the stack pointer and increment it; a concurrent load/set/clr still updates flags.
REQ-022 pop with the stack not empty SHALL decrement the pointer and load flags from that entry at the same edge.
REQ-023 push while full SHALL be ignored (no write, pointer held) and SHALL set stack_err.
REQ-024 pop while empty SHALL be ignored (flags unaffected by pop; lower-priority flag requests then apply) and SHALL set stack_err.
REQ-025 push and pop in the same cycle SHALL both be ignored, SHALL set stack_err, and lower-priority flag requests SHALL still apply.
REQ-026 The stack pointer SHALL span 0..STACK_DEPTH with no wrap-around; stack_empty is asserted at 0 and stack_full at STACK_DEPTH.
REQ-027 stack_err SHALL remain set until reset.

Reset
REQ-028 reset SHALL force flags=000, pointer=0, stack_empty=1, stack_full=0, stack_err=0, overriding all other inputs in that cycle.
REQ-029 Stack entry contents SHALL NOT require reset; an entry is never read before it is written.
REQ-030 reset mid-sequence SHALL discard all saved entries; a following pop SHALL be an underflow error.

Structure
REQ-031 arch_defs_pkg SHALL hold the cond_sel enum, the FLAG_Z/FLAG_C/FLAG_N bit-index constants and the default STACK_DEPTH.
REQ-032 The stack MAY be a single sub-module, flag_stack (storage array, pointer, full/empty, error); flag muxing and the condition decode stay in status_unit.

Verification
REQ-033 Reset, then load_nzc with Z=1,C=1,N=0 -> flags=010+Z (N0,C1,Z1); cond_sel=001 and 011 -> cond_true=1; cond_sel=111 -> 0.
REQ-034 flags=C1, then load_nz with Z=0,N=1 -> flags N1,C1,Z0 (C held); clr_carry -> C0; same-cycle set_carry+clr_carry -> C1.
REQ-035 Push four distinct values, a fifth push -> stack_full=1, stack_err=1, pointer held; four pops -> values restored LIFO, stack_empty=1.
REQ-036 pop while empty together with load_nzc Z=1 -> flags load from ALU, stack_err=1; push+pop in one cycle -> pointer unchanged, stack_err=1.
REQ-037 Push then pop together with load_nzc in the same cycle -> the popped value wins; reset after two pushes -> stack_empty=1, stack_err=0, flags=000.
